// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg -- shared definitions for the multiply/divide sequencer.
//   op_e     : EX-stage operation encodings (codes 6-7 are unused/ignored)
//   state_e  : sequencer FSM states
//   MUL_LAT  : cycles busy is held for MULT/MULTU
//   DIV_LAT  : cycles busy is held for DIV/DIVU
// -----------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_e;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    // Multiply and divide are the only ops that occupy the unit for several cycles.
    function automatic logic is_multicycle(input logic [2:0] op);
        return op <= 3'd3;
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// -----------------------------------------------------------------------------
// md_sequencer_if -- request/result bundle between the EX stage and the
// multiply/divide sequencer.
//   start, op, a, b, flush : request side, driven by the pipeline (master)
//   busy, stall, done      : status back to the pipeline / hazard unit
//   hi, lo                 : architectural HI/LO registers
// -----------------------------------------------------------------------------
interface md_sequencer_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, stall, done, hi, lo
    );

endinterface

// File: rtl/md_alu.sv
// -----------------------------------------------------------------------------
// md_alu -- purely combinational multiply/divide datapath.
//   op    : operation code (md_pkg::op_e encoding)
//   a, b  : latched operands
//   hi_n  : next HI value (product high word or remainder)
//   lo_n  : next LO value (product low word or quotient)
//   div0  : divide op with a zero divisor; HI/LO must not be written
// -----------------------------------------------------------------------------
module md_alu
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        div0
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               is_div;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        b_safe;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;

    // One unsigned divider serves both DIV and DIVU: signed division works on
    // magnitudes and re-applies the signs afterwards. Negating 0x80000000
    // yields 0x80000000, which is the correct unsigned magnitude, so the
    // 0x80000000 / -1 overflow case falls out naturally as lo=0x80000000, hi=0.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hi_n   = '0;
        lo_n   = '0;
        prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u = {32'b0, a} * {32'b0, b};
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        a_neg  = (op == OP_DIV) && a[31];
        b_neg  = (op == OP_DIV) && b[31];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        div0   = is_div && (b == 32'd0);
        // Keep the divider's divisor non-zero; the result is discarded on div0.
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;

        case (op)
            OP_MULT:  {hi_n, lo_n} = prod_s;
            OP_MULTU: {hi_n, lo_n} = prod_u;
            OP_DIV, OP_DIVU: begin
                lo_n = (a_neg ^ b_neg) ? -q_mag : q_mag;
                hi_n = a_neg ? -r_mag : r_mag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer -- multi-cycle MULT/DIV sequencer owning the HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : md_sequencer_if.slave
//           start/op/a/b : request, accepted only in IDLE
//           flush        : abort the in-flight operation (wins over start)
//           busy         : multi-cycle op in progress (registered)
//           stall        : combinational hold request to the hazard unit
//           done         : one-cycle pulse after HI/LO are loaded
//           hi/lo        : architectural registers, straight from flops
// -----------------------------------------------------------------------------
module md_sequencer
    import md_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    md_sequencer_if.slave  bus
);

    state_e      state_q, state_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q, done_n;
    logic        accept;
    logic        load_hilo;
    logic        write_hi;
    logic        write_lo;
    logic [31:0] alu_hi, alu_lo;
    logic        alu_div0;

    // The ALU only ever sees the latched operands, so a/b may change freely
    // while busy.
    md_alu u_alu (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi_n (alu_hi),
        .lo_n (alu_lo),
        .div0 (alu_div0)
    );

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        done_n    = 1'b0;
        accept    = 1'b0;
        load_hilo = 1'b0;
        write_hi  = 1'b0;
        write_lo  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            accept  = 1'b1;
                            state_n = ST_MUL;
                            cnt_n   = 4'(MUL_LAT - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            accept  = 1'b1;
                            state_n = ST_DIV;
                            cnt_n   = 4'(DIV_LAT - 1);
                        end
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (bus.flush) begin
                    state_n = ST_IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_n   = ST_IDLE;
                    done_n    = 1'b1;
                    // A zero divisor still runs the full latency and pulses
                    // done, but leaves HI/LO untouched.
                    load_hilo = !alu_div0;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_n;
            cnt_q   <= cnt_n;
            done_q  <= done_n;
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
            if (load_hilo) begin
                hi_q <= alu_hi;
                lo_q <= alu_lo;
            end else begin
                if (write_hi) hi_q <= bus.a;
                if (write_lo) lo_q <= bus.a;
            end
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    // Hold the pipeline as soon as a multi-cycle op is presented, not only
    // once it has been accepted.
    assign bus.stall = (bus.start && is_multicycle(bus.op)) || bus.busy;

endmodule

// File: tb/tb_md_sequencer.sv
// -----------------------------------------------------------------------------
// tb_md_sequencer -- directed self-checking bench for md_sequencer.
// Expected HI/LO results are computed by a behavioural model when an op is
// issued, queued, and compared when the DUT pulses done.
// -----------------------------------------------------------------------------
module tb_md_sequencer;
    import md_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    md_sequencer_if mif ();

    md_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Behavioural reference, written with 64-bit integer arithmetic.
    task automatic model_update(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb_, sq, sr;
        longint unsigned ua, ub, up;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (op)
            3'd0: begin sq = sa * sb_; model_hi = sq[63:32]; model_lo = sq[31:0]; end
            3'd1: begin up = ua * ub;  model_hi = up[63:32]; model_lo = up[31:0]; end
            3'd2: if (b != 0) begin
                sq = sa / sb_; sr = sa % sb_;
                model_lo = sq[31:0]; model_hi = sr[31:0];
            end
            3'd3: if (b != 0) begin
                model_lo = 32'(ua / ub); model_hi = 32'(ua % ub);
            end
            3'd4: model_hi = a;
            3'd5: model_lo = a;
            default: ;
        endcase
    endtask

    // Drive a request at the current negedge; multi-cycle ops queue a result.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        exp_t e;
        mif.start = 1'b1;
        mif.op    = op;
        mif.a     = a;
        mif.b     = b;
        model_update(op, a, b);
        if (op <= 3'd3) begin
            e.hi = model_hi; e.lo = model_lo; e.tag = tag;
            sb.push_back(e);
        end
        #1;
        check({tag, "_stall_on_req"}, mif.stall, (op <= 3'd3) ? 1 : 0);
    endtask

    // Called at the first negedge after acceptance; returns at the done-cycle negedge.
    task automatic wait_busy(input int lat, input string tag);
        int   cycles;
        logic stall_ok;
        exp_t e;
        cycles   = 0;
        stall_ok = 1'b1;
        while (mif.busy === 1'b1 && cycles < 40) begin
            if (mif.stall !== 1'b1) stall_ok = 1'b0;
            cycles++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, cycles, lat);
        check({tag, "_stall_held"}, stall_ok, 1);
        check({tag, "_done"}, mif.done, 1);
        check({tag, "_result_pending"}, (sb.size() != 0) ? 1 : 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_hi"}, mif.hi, e.hi);
            check({e.tag, "_lo"}, mif.lo, e.lo);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input string tag);
        issue(op, a, b, tag);
        @(negedge clk);
        mif.start = 1'b0;
        mif.a     = ~a;
        mif.b     = ~b;
        wait_busy(lat, tag);
    endtask

    task automatic done_drops(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse_width"}, mif.done, 0);
    endtask

    initial begin
        logic seen_done;
        n_checks  = 0;
        n_fail    = 0;
        model_hi  = '0;
        model_lo  = '0;
        mif.start = 1'b0;
        mif.op    = 3'd0;
        mif.a     = '0;
        mif.b     = '0;
        mif.flush = 1'b0;
        reset     = 1'b1;
        #1 reset  = 1'b0;
        #2;
        // Reset takes effect before any clock edge.
        check("rst_busy",  mif.busy,  0);
        check("rst_done",  mif.done,  0);
        check("rst_stall", mif.stall, 0);
        check("rst_hi",    mif.hi,    0);
        check("rst_lo",    mif.lo,    0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // First start right after release is accepted on the next rising edge.
        run_op(3'd0, 32'hFFFF_FFFF, 32'd2, MUL_LAT, "mult_neg1x2");
        check("mult_neg1x2_hi_const", mif.hi, 32'hFFFF_FFFF);
        check("mult_neg1x2_lo_const", mif.lo, 32'hFFFF_FFFE);
        done_drops("mult_neg1x2");

        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, MUL_LAT, "multu_ffx2");
        check("multu_ffx2_hi_const", mif.hi, 32'h0000_0001);
        done_drops("multu_ffx2");

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, DIV_LAT, "div_m7_2");
        check("div_m7_2_lo_const", mif.lo, 32'hFFFF_FFFD);
        check("div_m7_2_hi_const", mif.hi, 32'hFFFF_FFFF);
        done_drops("div_m7_2");

        run_op(3'd3, 32'd7, 32'd0, DIV_LAT, "divu_by0");
        done_drops("divu_by0");

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, "div_ovf");
        check("div_ovf_lo_const", mif.lo, 32'h8000_0000);
        check("div_ovf_hi_const", mif.hi, 32'h0);
        done_drops("div_ovf");

        run_op(3'd3, 32'hF000_0001, 32'd16, DIV_LAT, "divu_big");
        done_drops("divu_big");
        run_op(3'd2, 32'd100, 32'hFFFF_FFF9, DIV_LAT, "div_pos_neg");
        done_drops("div_pos_neg");
        run_op(3'd0, 32'h8000_0001, 32'h7FFF_FFFF, MUL_LAT, "mult_mixed");
        done_drops("mult_mixed");

        // MTHI / MTLO: one-edge write, no busy, no done.
        issue(3'd4, 32'hAAAA_5555, 32'd0, "mthi");
        @(negedge clk);
        mif.start = 1'b0;
        check("mthi_hi",   mif.hi,   model_hi);
        check("mthi_busy", mif.busy, 0);
        check("mthi_done", mif.done, 0);
        issue(3'd5, 32'h1357_9BDF, 32'd0, "mtlo");
        @(negedge clk);
        mif.start = 1'b0;
        check("mtlo_lo",   mif.lo,   model_lo);
        check("mtlo_hi",   mif.hi,   model_hi);
        check("mtlo_done", mif.done, 0);

        // Unused op code is ignored.
        issue(3'd6, 32'hDEAD_BEEF, 32'd1, "op6");
        @(negedge clk);
        mif.start = 1'b0;
        check("op6_busy", mif.busy, 0);
        check("op6_hi",   mif.hi,   model_hi);
        check("op6_lo",   mif.lo,   model_lo);

        // flush and start together in IDLE: flush wins.
        mif.flush = 1'b1;
        mif.start = 1'b1;
        mif.op    = 3'd4;
        mif.a     = 32'h0BAD_0BAD;
        @(negedge clk);
        mif.start = 1'b0;
        mif.flush = 1'b0;
        check("flush_idle_busy", mif.busy, 0);
        check("flush_idle_hi",   mif.hi,   model_hi);
        mif.flush = 1'b1;
        mif.start = 1'b1;
        mif.op    = 3'd0;
        @(negedge clk);
        mif.start = 1'b0;
        mif.flush = 1'b0;
        check("flush_idle_mult_busy", mif.busy, 0);
        @(negedge clk);
        check("flush_idle_mult_done", mif.done, 0);

        // MTHI presented during busy cycle 2 of a MULT is ignored.
        issue(3'd0, 32'h0001_2345, 32'hFFAB_CDEF, "mult_vs_mthi");
        @(negedge clk);
        mif.start = 1'b0;
        check("mult_vs_mthi_c1_stall", mif.stall, 1);
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = 3'd4;
        mif.a     = 32'h0000_1234;
        #1;
        check("mult_vs_mthi_c2_stall", mif.stall, 1);
        @(negedge clk);
        mif.start = 1'b0;
        wait_busy(MUL_LAT - 2, "mult_vs_mthi");
        done_drops("mult_vs_mthi");

        // Flush in busy cycle 3 of a DIV, then a MULT the following cycle.
        issue(3'd2, 32'd1000, 32'd7, "div_flushed");
        void'(sb.pop_back());
        model_hi = mif.hi;
        model_lo = mif.lo;
        @(negedge clk);
        mif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mif.flush = 1'b1;
        @(negedge clk);
        mif.flush = 1'b0;
        check("flush_busy", mif.busy, 0);
        check("flush_done", mif.done, 0);
        check("flush_hi",   mif.hi,   model_hi);
        check("flush_lo",   mif.lo,   model_lo);
        run_op(3'd1, 32'h0000_FFFF, 32'h0001_0001, MUL_LAT, "mult_after_flush");
        done_drops("mult_after_flush");

        // Back-to-back: a MULT started in the done cycle of another MULT.
        run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, MUL_LAT, "b2b_first");
        issue(3'd0, 32'h0000_0010, 32'hFFFF_FFF0, "b2b_second");
        @(negedge clk);
        mif.start = 1'b0;
        wait_busy(MUL_LAT, "b2b_second");
        done_drops("b2b_second");

        // Reset between edges in busy cycle 4 of a DIV.
        issue(3'd3, 32'd12345, 32'd67, "div_reset");
        @(negedge clk);
        mif.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", mif.busy, 0);
        check("midrst_hi",   mif.hi,   0);
        check("midrst_lo",   mif.lo,   0);
        sb.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset     = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (mif.done !== 1'b0) seen_done = 1'b1;
        end
        check("midrst_no_done", seen_done, 0);
        check("midrst_idle",    mif.busy,  0);

        run_op(3'd0, 32'd3, 32'd5, MUL_LAT, "mult_after_reset");
        done_drops("mult_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
